// File: rtl/matmul_host_adapter.sv
// Host-side adapter for the systolic matmul core: buffers A/B from the host, streams them
// to the core on go, captures the indexed result stream and serves host reads.
module matmul_host_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int TIMEOUT    = 1024,
    parameter int AW         = $clog2((M*K > K*N) ? ((M*K > M*N) ? M*K : M*N)
                                                  : ((K*N > M*N) ? K*N : M*N))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  count_err,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mm_start,
    output logic [DATA_WIDTH-1:0] mm_a_data,
    output logic [$clog2(M)-1:0]  mm_a_row,
    output logic [$clog2(K)-1:0]  mm_a_col,
    output logic                  mm_a_valid,
    output logic [DATA_WIDTH-1:0] mm_b_data,
    output logic [$clog2(K)-1:0]  mm_b_row,
    output logic [$clog2(N)-1:0]  mm_b_col,
    output logic                  mm_b_valid,
    input  logic [DATA_WIDTH-1:0] mm_c_data,
    input  logic [$clog2(M)-1:0]  mm_c_row,
    input  logic [$clog2(N)-1:0]  mm_c_col,
    input  logic                  mm_c_valid,
    input  logic                  mm_done
);
    localparam int MK    = M * K;
    localparam int KN    = K * N;
    localparam int MN    = M * N;
    localparam int S     = (MK > KN) ? MK : KN;
    localparam int MW    = $clog2(M);
    localparam int KW    = $clog2(K);
    localparam int NW    = $clog2(N);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CMAX  = (TIMEOUT > MN) ? TIMEOUT : MN;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, FINISH} state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] a_mem   [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] b_mem   [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] res_mem [0:DEPTH-1];

    logic [AW:0]           idx_reg;
    logic [MW-1:0]         a_row_cnt_reg;
    logic [KW-1:0]         a_col_cnt_reg;
    logic [KW-1:0]         b_row_cnt_reg;
    logic [NW-1:0]         b_col_cnt_reg;
    logic [TW-1:0]         wait_cnt_reg;
    logic [CW-1:0]         res_cnt_reg;
    logic [CW-1:0]         res_cnt_next;

    logic                  busy_reg, done_reg, timeout_err_reg, count_err_reg, mm_start_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg, mm_a_data_reg, mm_b_data_reg;
    logic [MW-1:0]         mm_a_row_reg;
    logic [KW-1:0]         mm_a_col_reg, mm_b_row_reg;
    logic [NW-1:0]         mm_b_col_reg;
    logic                  mm_a_valid_reg, mm_b_valid_reg;

    logic                  a_we, b_we, c_we, a_live, b_live;
    logic [AW:0]           c_flat;

    // Operands are only writable while idle so a run always sees a frozen snapshot.
    assign a_we   = !rst && (state_reg == IDLE) && wr_en && !wr_sel && ({1'b0, wr_addr} < (AW+1)'(MK));
    assign b_we   = !rst && (state_reg == IDLE) && wr_en &&  wr_sel && ({1'b0, wr_addr} < (AW+1)'(KN));
    assign c_flat = (AW+1)'(mm_c_row) * (AW+1)'(N) + (AW+1)'(mm_c_col);
    assign c_we   = !rst && (state_reg == WAIT) && mm_c_valid &&
                    (c_flat < (AW+1)'(MN)) && ((AW+1)'(mm_c_col) < (AW+1)'(N));
    assign a_live = idx_reg < (AW+1)'(MK);
    assign b_live = idx_reg < (AW+1)'(KN);
    assign res_cnt_next = res_cnt_reg + CW'(mm_c_valid);

    always_ff @(posedge clk) begin
        if (a_we) a_mem[wr_addr] <= wr_data;
        if (b_we) b_mem[wr_addr] <= wr_data;
        if (c_we) res_mem[c_flat[AW-1:0]] <= mm_c_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= '0;
        else if ({1'b0, rd_addr} < (AW+1)'(MN))
            rd_data_reg <= res_mem[rd_addr];
        else
            rd_data_reg <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            a_row_cnt_reg   <= '0;
            a_col_cnt_reg   <= '0;
            b_row_cnt_reg   <= '0;
            b_col_cnt_reg   <= '0;
            wait_cnt_reg    <= '0;
            res_cnt_reg     <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            count_err_reg   <= 1'b0;
            mm_start_reg    <= 1'b0;
            mm_a_valid_reg  <= 1'b0;
            mm_a_data_reg   <= '0;
            mm_a_row_reg    <= '0;
            mm_a_col_reg    <= '0;
            mm_b_valid_reg  <= 1'b0;
            mm_b_data_reg   <= '0;
            mm_b_row_reg    <= '0;
            mm_b_col_reg    <= '0;
        end else begin
            mm_start_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        state_reg       <= START;
                        busy_reg        <= 1'b1;
                        mm_start_reg    <= 1'b1;
                        timeout_err_reg <= 1'b0;
                        count_err_reg   <= 1'b0;
                        idx_reg         <= '0;
                        a_row_cnt_reg   <= '0;
                        a_col_cnt_reg   <= '0;
                        b_row_cnt_reg   <= '0;
                        b_col_cnt_reg   <= '0;
                    end
                end
                // START issues element 0 so the first valid lands the cycle after mm_start.
                START, STREAM: begin
                    if (idx_reg == (AW+1)'(S)) begin
                        state_reg      <= WAIT;
                        mm_a_valid_reg <= 1'b0;
                        mm_a_data_reg  <= '0;
                        mm_a_row_reg   <= '0;
                        mm_a_col_reg   <= '0;
                        mm_b_valid_reg <= 1'b0;
                        mm_b_data_reg  <= '0;
                        mm_b_row_reg   <= '0;
                        mm_b_col_reg   <= '0;
                        wait_cnt_reg   <= '0;
                        res_cnt_reg    <= '0;
                    end else begin
                        state_reg      <= STREAM;
                        idx_reg        <= idx_reg + (AW+1)'(1);
                        mm_a_valid_reg <= a_live;
                        mm_a_data_reg  <= a_live ? a_mem[idx_reg[AW-1:0]] : '0;
                        mm_a_row_reg   <= a_live ? a_row_cnt_reg : '0;
                        mm_a_col_reg   <= a_live ? a_col_cnt_reg : '0;
                        mm_b_valid_reg <= b_live;
                        mm_b_data_reg  <= b_live ? b_mem[idx_reg[AW-1:0]] : '0;
                        mm_b_row_reg   <= b_live ? b_row_cnt_reg : '0;
                        mm_b_col_reg   <= b_live ? b_col_cnt_reg : '0;
                        if (a_col_cnt_reg == KW'(K - 1)) begin
                            a_col_cnt_reg <= '0;
                            a_row_cnt_reg <= a_row_cnt_reg + MW'(1);
                        end else begin
                            a_col_cnt_reg <= a_col_cnt_reg + KW'(1);
                        end
                        if (b_col_cnt_reg == NW'(N - 1)) begin
                            b_col_cnt_reg <= '0;
                            b_row_cnt_reg <= b_row_cnt_reg + KW'(1);
                        end else begin
                            b_col_cnt_reg <= b_col_cnt_reg + NW'(1);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + TW'(1);
                    if (mm_c_valid)
                        res_cnt_reg <= res_cnt_next;
                    if (mm_done || (wait_cnt_reg == TW'(TIMEOUT - 1))) begin
                        state_reg       <= FINISH;
                        busy_reg        <= 1'b0;
                        done_reg        <= 1'b1;
                        timeout_err_reg <= !mm_done;
                        count_err_reg   <= (res_cnt_next != CW'(MN));
                    end
                end
                FINISH:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timeout_err = timeout_err_reg;
    assign count_err   = count_err_reg;
    assign rd_data     = rd_data_reg;
    assign mm_start    = mm_start_reg;
    assign mm_a_data   = mm_a_data_reg;
    assign mm_a_row    = mm_a_row_reg;
    assign mm_a_col    = mm_a_col_reg;
    assign mm_a_valid  = mm_a_valid_reg;
    assign mm_b_data   = mm_b_data_reg;
    assign mm_b_row    = mm_b_row_reg;
    assign mm_b_col    = mm_b_col_reg;
    assign mm_b_valid  = mm_b_valid_reg;

endmodule

// File: tb/tb_matmul_host_adapter.sv
// Directed bench for matmul_host_adapter: the initial block plays both host and core,
// checking stream order/timing, completion, sticky errors, reset and result reads.
module tb_matmul_host_adapter;
    localparam int DW = 16;
    localparam int M  = 4;
    localparam int N  = 2;
    localparam int K  = 3;
    localparam int TO = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_sel, go;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic          busy, done, timeout_err, count_err, mm_start;
    logic [DW-1:0] mm_a_data, mm_b_data, mm_c_data;
    logic [1:0]    mm_a_row, mm_a_col, mm_b_row, mm_c_row;
    logic          mm_b_col, mm_c_col;
    logic          mm_a_valid, mm_b_valid, mm_c_valid, mm_done;

    logic [DW-1:0] ref_a [12];
    logic [DW-1:0] ref_b [6];
    logic [DW-1:0] cval  [8];
    logic [DW-1:0] exp_idx [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                                   16'h0500, 16'h0600, 16'h0000, 16'h0000};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matmul_host_adapter #(
        .DATA_WIDTH(DW), .M(M), .N(N), .K(K), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .busy(busy), .done(done),
        .timeout_err(timeout_err), .count_err(count_err),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .mm_start(mm_start),
        .mm_a_data(mm_a_data), .mm_a_row(mm_a_row), .mm_a_col(mm_a_col), .mm_a_valid(mm_a_valid),
        .mm_b_data(mm_b_data), .mm_b_row(mm_b_row), .mm_b_col(mm_b_col), .mm_b_valid(mm_b_valid),
        .mm_c_data(mm_c_data), .mm_c_row(mm_c_row), .mm_c_col(mm_c_col),
        .mm_c_valid(mm_c_valid), .mm_done(mm_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input int addr, input logic [DW-1:0] exp);
        @(negedge clk);
        rd_addr = AW'(addr);
        @(negedge clk);
        check($sformatf("rd[%0d]", addr), 32'(rd_data), 32'(exp));
        $display("read  result[%0d] = 0x%04h", addr, rd_data);
    endtask

    task automatic load_all(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < 12; i++) begin ref_a[i] = av; wr(1'b0, i, av); end
        for (int i = 0; i < 6; i++)  begin ref_b[i] = bv; wr(1'b1, i, bv); end
    endtask

    task automatic load_index();
        for (int i = 0; i < 12; i++) begin
            ref_a[i] = (i == 0 || i == 4 || i == 8) ? 16'h0100 : 16'h0000;
            wr(1'b0, i, ref_a[i]);
        end
        for (int i = 0; i < 6; i++) begin
            ref_b[i] = DW'(16'h0100 * (i + 1));
            wr(1'b1, i, ref_b[i]);
        end
    endtask

    task automatic check_all_zero();
        check("rst_busy",  32'(busy), 0);        check("rst_done",  32'(done), 0);
        check("rst_terr",  32'(timeout_err), 0); check("rst_cerr",  32'(count_err), 0);
        check("rst_start", 32'(mm_start), 0);    check("rst_rdata", 32'(rd_data), 0);
        check("rst_avld",  32'(mm_a_valid), 0);  check("rst_bvld",  32'(mm_b_valid), 0);
        check("rst_adata", 32'(mm_a_data), 0);   check("rst_bdata", 32'(mm_b_data), 0);
        check("rst_arow",  32'(mm_a_row), 0);    check("rst_acol",  32'(mm_a_col), 0);
        check("rst_brow",  32'(mm_b_row), 0);    check("rst_bcol",  32'(mm_b_col), 0);
    endtask

    // One run: go, stream checks, then the core stand-in answers (or stays silent).
    task automatic run(input string name, input int n_res, input int skip, input bit dead,
                       input bit poke, input int rst_at, input bit exp_cerr, input bit exp_terr);
        int cyc;
        int prev;
        int emitted;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                int acc = 0;
                for (int k = 0; k < K; k++)
                    acc += int'($signed(ref_a[i*K+k])) * int'($signed(ref_b[k*N+j]));
                cval[i*N+j] = DW'(acc >>> 8);
            end
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        check("busy_T1", 32'(busy), 1);
        check("start_T1", 32'(mm_start), 1);
        check("avld_T1", 32'(mm_a_valid), 0);
        check("terr_clr", 32'(timeout_err), 0);
        check("cerr_clr", 32'(count_err), 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (poke) begin go = 1'b0; wr_en = 1'b0; end
            check("start_low", 32'(mm_start), 0);
            check("a_valid", 32'(mm_a_valid), 1);
            check("a_row", 32'(mm_a_row), c / 3);
            check("a_col", 32'(mm_a_col), c % 3);
            check("a_data", 32'(mm_a_data), 32'(ref_a[c]));
            check("b_valid", 32'(mm_b_valid), 32'(c < 6));
            if (c < 6) begin
                check("b_row", 32'(mm_b_row), c / 2);
                check("b_col", 32'(mm_b_col), c % 2);
                check("b_data", 32'(mm_b_data), 32'(ref_b[c]));
            end
            if (poke && c == 3) begin
                go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(11); wr_data = 16'h7777;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_all_zero();
                $display("run   %s: reset mid-stream", name);
                return;
            end
        end
        @(negedge clk);
        check("a_valid_end", 32'(mm_a_valid), 0);
        check("b_valid_end", 32'(mm_b_valid), 0);
        check("busy_wait", 32'(busy), 1);
        if (dead) begin
            cyc = 0;
            while (!done && cyc < 40) begin @(negedge clk); cyc++; end
            check("timeout_cycles", 32'(cyc), 16);
        end else begin
            emitted = 0;
            prev = -1;
            for (int i = 0; i < 8; i++) begin
                if (i == skip) continue;
                emitted++;
                mm_c_valid = 1'b1; mm_c_row = 2'(i / 2); mm_c_col = 1'(i % 2);
                mm_c_data = cval[i]; mm_done = (emitted == n_res);
                if (prev >= 0) rd_addr = AW'(prev);
                @(negedge clk);
                if (prev >= 0) check("wr_then_rd", 32'(rd_data), 32'(cval[prev]));
                prev = i;
            end
            mm_c_valid = 1'b0; mm_done = 1'b0;
        end
        check("done_pulse", 32'(done), 1);
        check("busy_finish", 32'(busy), 0);
        check("timeout_err", 32'(timeout_err), 32'(exp_terr));
        check("count_err", 32'(count_err), 32'(exp_cerr));
        @(negedge clk);
        check("done_low", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        $display("run   %s: done, timeout_err=%0b count_err=%0b", name, timeout_err, count_err);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
        rd_addr = '0; mm_c_data = '0; mm_c_row = '0; mm_c_col = 1'b0;
        mm_c_valid = 1'b0; mm_done = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        load_all(16'h0100, 16'h0200);
        run("basic", 8, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) rd_chk(i, 16'h0600);
        rd_chk(9, 16'h0000);
        rd_chk(15, 16'h0000);

        load_index();
        run("index", 8, -1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) rd_chk(i, exp_idx[i]);

        run("dead", 0, -1, 1'b1, 1'b0, -1, 1'b1, 1'b1);
        rd_chk(3, 16'h0400);

        load_all(16'h0100, 16'h0200);
        run("short", 7, 3, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) rd_chk(i, (i == 3) ? 16'h0400 : 16'h0600);

        run("reset", 8, -1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run("fresh", 8, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) rd_chk(i, 16'h0600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
